// File: rtl/jtcps1_prom_we_buf.sv
`default_nettype none
// ============================================================================
// Module   : jtcps1_prom_we_buf
// Purpose  : Buffered ROM-download write generator. Takes the byte-wide
//            ioctl download stream, optionally packs even/odd byte pairs
//            into 16-bit words, maps byte addresses onto one of four SDRAM
//            banks and queues the resulting writes in a small FIFO so that
//            download bursts are decoupled from the SDRAM ack latency.
//            Header bytes (address < REGSIZE) are also strobed out on cfg_*.
// Ports    :
//   clk, rst_n           clock, asynchronous active-low reset
//   downloading          download window active
//   ioctl_addr/data/wr   byte address, byte data, one-cycle byte strobe
//   prog_addr/data/mask  bank-relative word address, 16-bit data,
//                        active-low byte enables (bit0 = [7:0])
//   prog_ba, prog_we     SDRAM bank, write request held until sdram_ack
//   sdram_ack            write accepted
//   cfg_we/addr/data     one-cycle header-byte strobe, index and value
//   busy                 hold register, FIFO or prog_we still active
//   overflow             sticky: at least one FIFO entry was dropped
// Revision : 1.0 - initial release
// ============================================================================
module jtcps1_prom_we_buf #(
   parameter int              AW        = 23,
   parameter int              FIFO_AW   = 2,
   parameter int              REGSIZE   = 1,
   parameter int              PACK      = 1,
   parameter logic [AW-1:0]   BA1_START = AW'(23'h10_0000),
   parameter logic [AW-1:0]   BA2_START = AW'(23'h20_0000),
   parameter logic [AW-1:0]   BA3_START = AW'(23'h40_0000)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            downloading,
   input  logic [AW-1:0]   ioctl_addr,
   input  logic [7:0]      ioctl_data,
   input  logic            ioctl_wr,
   output logic [AW-2:0]   prog_addr,
   output logic [15:0]     prog_data,
   output logic [1:0]      prog_mask,
   output logic [1:0]      prog_ba,
   output logic            prog_we,
   input  logic            sdram_ack,
   output logic            cfg_we,
   output logic [4:0]      cfg_addr,
   output logic [7:0]      cfg_data,
   output logic            busy,
   output logic            overflow
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   // FIFO entry layout: {ba[1:0], word_addr[AW-2:0], data[15:0], mask[1:0]}
   localparam int                 c_EW      = 2 + (AW - 1) + 16 + 2;
   localparam int                 c_DEPTH   = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   c_FULL    = (FIFO_AW + 1)'(c_DEPTH);
   localparam logic [AW-1:0]      c_REGSIZE = AW'(REGSIZE);

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_REQ  = 2'd1;
   localparam logic [1:0] c_S_GAP  = 2'd2;

   // ------------------------------------------------------------------------
   // Entry construction helpers
   // ------------------------------------------------------------------------
   // Bank selection by region, then bank-relative word address. The
   // subtraction is AW bits wide, so the word address wraps naturally.
   function automatic logic [c_EW-1:0] f_make_entry(
      input logic [AW-1:0] a,
      input logic [15:0]   d,
      input logic [1:0]    m
   );
      logic [1:0]    ba;
      logic [AW-1:0] start;
      logic [AW-1:0] diff;
      if (a >= BA3_START) begin
         ba    = 2'd3;
         start = BA3_START;
      end else if (a >= BA2_START) begin
         ba    = 2'd2;
         start = BA2_START;
      end else if (a >= BA1_START) begin
         ba    = 2'd1;
         start = BA1_START;
      end else begin
         ba    = 2'd0;
         start = '0;
      end
      diff = a - start;
      return {ba, diff[AW-1:1], d, m};
   endfunction

   // A lone byte is replicated on both lanes; only its own lane is enabled.
   function automatic logic [c_EW-1:0] f_single(
      input logic [AW-1:0] a,
      input logic [7:0]    d
   );
      return f_make_entry(a, {d, d}, a[0] ? 2'b01 : 2'b10);
   endfunction

   // ------------------------------------------------------------------------
   // Input qualification and download edge detection
   // ------------------------------------------------------------------------
   logic w_acc;
   logic r_dl_d;
   logic w_dl_fall;
   logic w_dl_rise;

   assign w_acc     = ioctl_wr & downloading;
   assign w_dl_fall = r_dl_d & ~downloading;
   assign w_dl_rise = ~r_dl_d & downloading;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dl_d <= 1'b0;
      end else begin
         r_dl_d <= downloading;
      end
   end

   // ------------------------------------------------------------------------
   // Config header capture
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_we   <= 1'b0;
         cfg_addr <= '0;
         cfg_data <= '0;
      end else begin
         cfg_we <= w_acc && (ioctl_addr < c_REGSIZE);
         if (w_acc && (ioctl_addr < c_REGSIZE)) begin
            cfg_addr <= ioctl_addr[4:0];
            cfg_data <= ioctl_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Packer: produces at most one FIFO push per cycle
   // ------------------------------------------------------------------------
   logic            r_hold_vld;
   logic [AW-1:0]   r_hold_addr;
   logic [7:0]      r_hold_data;
   logic            w_hold_vld_nxt;
   logic [AW-1:0]   w_hold_addr_nxt;
   logic [7:0]      w_hold_data_nxt;
   logic            w_push;
   logic [c_EW-1:0] w_push_entry;

   generate
      if (PACK != 0) begin : g_pack
         always_comb begin
            w_push          = 1'b0;
            w_push_entry    = '0;
            w_hold_vld_nxt  = r_hold_vld;
            w_hold_addr_nxt = r_hold_addr;
            w_hold_data_nxt = r_hold_data;
            if (r_hold_vld) begin
               if (w_acc) begin
                  w_push = 1'b1;
                  if (!r_hold_addr[0] && (ioctl_addr == r_hold_addr + AW'(1))) begin
                     // Even byte followed by its odd partner: one word write.
                     w_push_entry   = f_make_entry(r_hold_addr,
                                                   {ioctl_data, r_hold_data},
                                                   2'b00);
                     w_hold_vld_nxt = 1'b0;
                  end else begin
                     // No partner: flush held byte, new byte takes its place.
                     w_push_entry    = f_single(r_hold_addr, r_hold_data);
                     w_hold_addr_nxt = ioctl_addr;
                     w_hold_data_nxt = ioctl_data;
                  end
               end else if (w_dl_fall) begin
                  // End of download: the last lone byte must not be lost.
                  w_push         = 1'b1;
                  w_push_entry   = f_single(r_hold_addr, r_hold_data);
                  w_hold_vld_nxt = 1'b0;
               end
            end else if (w_acc) begin
               w_hold_vld_nxt  = 1'b1;
               w_hold_addr_nxt = ioctl_addr;
               w_hold_data_nxt = ioctl_data;
            end
         end
      end else begin : g_nopack
         always_comb begin
            w_push          = w_acc;
            w_push_entry    = f_single(ioctl_addr, ioctl_data);
            w_hold_vld_nxt  = 1'b0;
            w_hold_addr_nxt = r_hold_addr;
            w_hold_data_nxt = r_hold_data;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_vld  <= 1'b0;
         r_hold_addr <= '0;
         r_hold_data <= '0;
      end else begin
         r_hold_vld  <= w_hold_vld_nxt;
         r_hold_addr <= w_hold_addr_nxt;
         r_hold_data <= w_hold_data_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Write FIFO
   // ------------------------------------------------------------------------
   logic [c_EW-1:0] r_mem [c_DEPTH];
   logic [FIFO_AW:0] r_wptr;
   logic [FIFO_AW:0] r_rptr;
   logic [FIFO_AW:0] w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_wr;
   logic             w_drop;
   logic             w_pop;
   logic [c_EW-1:0]  w_head;

   assign w_count = r_wptr - r_rptr;
   assign w_full  = (w_count == c_FULL);
   assign w_empty = (r_wptr == r_rptr);
   // A push into a full FIFO still fits when the head leaves the same cycle.
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & ~w_wr;
   assign w_head  = r_mem[r_rptr[FIFO_AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr[FIFO_AW-1:0]] <= w_push_entry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + (FIFO_AW + 1)'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + (FIFO_AW + 1)'(1);
         end
      end
   end

   // Set wins over clear so a drop on the very first cycle of a new
   // download is still reported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (w_drop) begin
         overflow <= 1'b1;
      end else if (w_dl_rise) begin
         overflow <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Output FSM: IDLE -> REQ (hold until ack) -> GAP -> IDLE
   // ------------------------------------------------------------------------
   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       w_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         c_S_IDLE: begin
            if (!w_empty) begin
               w_load      = 1'b1;
               w_state_nxt = c_S_REQ;
            end
         end
         c_S_REQ: begin
            // The head stays in the FIFO until the SDRAM takes it.
            if (sdram_ack) begin
               w_pop       = 1'b1;
               w_state_nxt = c_S_GAP;
            end
         end
         c_S_GAP: begin
            w_state_nxt = c_S_IDLE;
         end
         default: begin
            w_state_nxt = c_S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prog_we   <= 1'b0;
         prog_ba   <= '0;
         prog_addr <= '0;
         prog_data <= '0;
         prog_mask <= 2'b11;
      end else if (w_load) begin
         prog_we   <= 1'b1;
         prog_ba   <= w_head[c_EW-1 -: 2];
         prog_addr <= w_head[c_EW-3 -: (AW - 1)];
         prog_data <= w_head[17:2];
         prog_mask <= w_head[1:0];
      end else if (w_pop) begin
         prog_we   <= 1'b0;
      end
   end

   assign busy = r_hold_vld | ~w_empty | prog_we;

endmodule
`default_nettype wire

// File: tb/tb_jtcps1_prom_we_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtcps1_prom_we_buf
// Purpose  : Directed, scoreboard-based bench for jtcps1_prom_we_buf.
//            dut0: PACK=1, REGSIZE=4, FIFO_AW=2. dut1: PACK=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtcps1_prom_we_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        downloading;
   logic [22:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic        sdram_ack;

   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask;
   logic [1:0]  prog_ba;
   logic        prog_we;
   logic        cfg_we;
   logic [4:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic        busy;
   logic        overflow;

   logic        dl1;
   logic        wr1;
   logic        ack1;
   logic [21:0] p1_addr;
   logic [15:0] p1_data;
   logic [1:0]  p1_mask;
   logic [1:0]  p1_ba;
   logic        p1_we;
   logic        p1_cfg_we;
   logic [4:0]  p1_cfg_addr;
   logic [7:0]  p1_cfg_data;
   logic        p1_busy;
   logic        p1_ovf;

   int n_checks = 0;
   int n_err    = 0;
   int n_cfg    = 0;

   logic [41:0] exp_q0[$];
   logic [41:0] exp_q1[$];
   logic [12:0] cfg_q[$];

   always #5 clk = ~clk;

   jtcps1_prom_we_buf #(
      .AW(23), .FIFO_AW(2), .REGSIZE(4), .PACK(1)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
      .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
      .prog_ba(prog_ba), .prog_we(prog_we), .sdram_ack(sdram_ack),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .busy(busy), .overflow(overflow)
   );

   jtcps1_prom_we_buf #(
      .AW(23), .FIFO_AW(2), .REGSIZE(1), .PACK(0)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .downloading(dl1),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(wr1),
      .prog_addr(p1_addr), .prog_data(p1_data), .prog_mask(p1_mask),
      .prog_ba(p1_ba), .prog_we(p1_we), .sdram_ack(ack1),
      .cfg_we(p1_cfg_we), .cfg_addr(p1_cfg_addr), .cfg_data(p1_cfg_data),
      .busy(p1_busy), .overflow(p1_ovf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [41:0] ent(input logic [1:0] ba, input logic [21:0] a,
                                       input logic [15:0] d, input logic [1:0] m);
      return {ba, a, d, m};
   endfunction

   function automatic logic [41:0] cur(input bit sel);
      return sel ? {p1_ba, p1_addr, p1_data, p1_mask}
                 : {prog_ba, prog_addr, prog_data, prog_mask};
   endfunction

   function automatic logic cur_we(input bit sel);
      return sel ? p1_we : prog_we;
   endfunction

   task automatic send_byte(input bit sel, input logic [22:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_data = d;
      if (sel) wr1 = 1'b1;
      else     ioctl_wr = 1'b1;
      @(posedge clk);
      #1;
      wr1      = 1'b0;
      ioctl_wr = 1'b0;
   endtask

   // Wait (bounded) for a write request, compare it to the scoreboard head,
   // keep it pending for ack_dly cycles checking stability, then ack it.
   task automatic expect_write(input bit sel, input int ack_dly);
      logic [41:0] e;
      logic [41:0] seen;
      int t;
      t = 0;
      @(negedge clk);
      while (cur_we(sel) !== 1'b1 && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk(sel ? "we1_timeout" : "we0_timeout", {63'd0, cur_we(sel)}, 64'd1);
      if (cur_we(sel) !== 1'b1) return;
      if (sel ? (exp_q1.size() == 0) : (exp_q0.size() == 0)) begin
         chk("unexpected_write", 64'd1, 64'd0);
         e = '0;
      end else begin
         e = sel ? exp_q1.pop_front() : exp_q0.pop_front();
      end
      seen = cur(sel);
      chk(sel ? "write1" : "write0", {22'd0, seen}, {22'd0, e});
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk);
         chk("hold_stable", {21'd0, cur_we(sel), cur(sel)}, {21'd0, 1'b1, seen});
      end
      if (sel) ack1 = 1'b1;
      else     sdram_ack = 1'b1;
      @(negedge clk);
      ack1      = 1'b0;
      sdram_ack = 1'b0;
      chk("we_after_ack", {63'd0, cur_we(sel)}, 64'd0);
   endtask

   // Config strobe monitor
   always @(negedge clk) begin
      if (cfg_we === 1'b1) begin
         n_cfg++;
         if (cfg_q.size() == 0) begin
            chk("cfg_extra", 64'd1, 64'd0);
         end else begin
            chk("cfg", {51'd0, cfg_addr, cfg_data}, {51'd0, cfg_q.pop_front()});
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no completion, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic bad;
      int t;
      rst_n       = 1'b0;
      downloading = 1'b0;
      ioctl_addr  = '0;
      ioctl_data  = '0;
      ioctl_wr    = 1'b0;
      sdram_ack   = 1'b0;
      dl1         = 1'b0;
      wr1         = 1'b0;
      ack1        = 1'b0;
      repeat (3) @(negedge clk);

      // ---- reset state ----
      chk("rst_prog_we", {63'd0, prog_we}, 64'd0);
      chk("rst_mask", {62'd0, prog_mask}, 64'd3);
      chk("rst_addr_data", {20'd0, prog_ba, prog_addr, prog_data}, 64'd0);
      chk("rst_busy_ovf_cfg", {61'd0, busy, overflow, cfg_we}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      downloading = 1'b1;
      dl1         = 1'b1;
      @(negedge clk);

      // ---- 1: even/odd pair packed into one word ----
      exp_q0.push_back(ent(2'd0, 22'h100, 16'h2211, 2'b00));
      send_byte(0, 23'h000200, 8'h11);
      send_byte(0, 23'h000201, 8'h22);
      expect_write(0, 2);

      // ---- 2: lone byte flushed by end of download ----
      exp_q0.push_back(ent(2'd1, 22'h000001, 16'hABAB, 2'b01));
      send_byte(0, 23'h100003, 8'hAB);
      repeat (2) @(negedge clk);
      chk("no_early_write", {63'd0, prog_we}, 64'd0);
      chk("busy_hold", {63'd0, busy}, 64'd1);
      downloading = 1'b0;
      expect_write(0, 1);
      @(negedge clk);
      chk("busy_after_flush", {63'd0, busy}, 64'd0);

      // ---- 3: header bytes 0..5 with REGSIZE=4 ----
      downloading = 1'b1;
      n_cfg = 0;
      for (int i = 0; i < 4; i++) cfg_q.push_back({5'(i), 8'(8'hC0 + i)});
      exp_q0.push_back(ent(2'd0, 22'h0, 16'hC1C0, 2'b00));
      exp_q0.push_back(ent(2'd0, 22'h1, 16'hC3C2, 2'b00));
      exp_q0.push_back(ent(2'd0, 22'h2, 16'hC5C4, 2'b00));
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) send_byte(0, 23'(i), 8'(8'hC0 + i));
      for (int i = 0; i < 3; i++) expect_write(0, 0);
      repeat (3) @(negedge clk);
      chk("cfg_count", 64'(n_cfg), 64'd4);

      // ---- 4: overflow with ack held low ----
      for (int i = 0; i < 4; i++)
         exp_q0.push_back(ent(2'd0, 22'(22'h180 + i), {2{8'(8'h50 + i)}}, 2'b01));
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) send_byte(0, 23'(23'h301 + 2 * i), 8'(8'h50 + i));
      repeat (3) @(negedge clk);
      chk("overflow_set", {63'd0, overflow}, 64'd1);
      chk("busy_full", {63'd0, busy}, 64'd1);
      for (int i = 0; i < 4; i++) expect_write(0, 0);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (prog_we !== 1'b0) bad = 1'b1;
      end
      chk("only_four_writes", {63'd0, bad}, 64'd0);
      exp_q0.push_back(ent(2'd0, 22'h18B, 16'h5B5B, 2'b01));
      downloading = 1'b0;
      expect_write(0, 0);
      chk("overflow_sticky", {63'd0, overflow}, 64'd1);
      downloading = 1'b1;
      repeat (2) @(negedge clk);
      chk("overflow_cleared", {63'd0, overflow}, 64'd0);

      // ---- 5: reset in the middle of a pending write ----
      send_byte(0, 23'h000500, 8'h77);
      send_byte(0, 23'h000501, 8'h78);
      t = 0;
      @(negedge clk);
      while (prog_we !== 1'b1 && t < 30) begin
         @(negedge clk);
         t++;
      end
      chk("rst_pre_we", {63'd0, prog_we}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_we", {63'd0, prog_we}, 64'd0);
      chk("rst_mid_mask", {62'd0, prog_mask}, 64'd3);
      chk("rst_mid_fields", {20'd0, prog_ba, prog_addr, prog_data}, 64'd0);
      chk("rst_mid_flags", {61'd0, busy, overflow, cfg_we}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (prog_we !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      chk("no_replay", {63'd0, bad}, 64'd0);
      exp_q0.push_back(ent(2'd0, 22'h300, 16'h9A99, 2'b00));
      send_byte(0, 23'h000600, 8'h99);
      send_byte(0, 23'h000601, 8'h9A);
      expect_write(0, 1);

      // ---- 6: PACK=0 instance ----
      exp_q1.push_back(ent(2'd3, 22'h0, 16'h3C3C, 2'b10));
      send_byte(1, 23'h400000, 8'h3C);
      expect_write(1, 1);
      exp_q1.push_back(ent(2'd0, 22'h8, 16'hA1A1, 2'b01));
      exp_q1.push_back(ent(2'd0, 22'h9, 16'hA2A2, 2'b10));
      @(posedge clk);
      #1;
      send_byte(1, 23'h000011, 8'hA1);
      send_byte(1, 23'h000012, 8'hA2);
      expect_write(1, 0);
      expect_write(1, 0);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q0.size() + exp_q1.size() + cfg_q.size()), 64'd0);
      chk("pack0_idle", {62'd0, p1_we, p1_busy}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jtcps1_prom_we_buf.md
Name: jtcps1_prom_we_buf

Overview:
- Buffered, parametrised successor of the CPS1 ROM-download write generator. Sits between the ioctl download stream and the SDRAM programming port.
- Packs consecutive even/odd bytes into 16-bit words and maps byte addresses onto up to four SDRAM banks by region.
- Queues writes in a FIFO so that ioctl bursts are decoupled from SDRAM ack latency, and captures the config header bytes.

Parameters:
- AW, 23: ioctl byte-address width.
- FIFO_AW, 2: log2 of FIFO depth (depth = 2**FIFO_AW entries).
- REGSIZE, 1: number of header bytes (0..31) that also pulse cfg_we.
- PACK, 1: 1 = pair even/odd bytes into word writes; 0 = one write per byte.
- BA1_START, 23'h10_0000: first byte address mapped to bank 1.
- BA2_START, 23'h20_0000: first byte address mapped to bank 2.
- BA3_START, 23'h40_0000: first byte address mapped to bank 3. Requires BA1 <= BA2 <= BA3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- downloading  in  1  download window active.
- ioctl_addr  in  AW  byte address.
- ioctl_data  in  8  byte data.
- ioctl_wr  in  1  single-cycle byte strobe.
- prog_addr  out  AW-1  bank-relative word address.
- prog_data  out  16  write data: even byte on [7:0], odd byte on [15:8].
- prog_mask  out  2  byte enables, active low: bit0 = [7:0], bit1 = [15:8].
- prog_ba  out  2  SDRAM bank.
- prog_we  out  1  write request, held until acked.
- sdram_ack  in  1  write accepted.
- cfg_we  out  1  one-cycle header-byte strobe.
- cfg_addr  out  5  header byte index.
- cfg_data  out  8  header byte.
- busy  out  1  holding register, FIFO or prog_we still active.
- overflow  out  1  sticky: at least one entry was dropped.

Behaviour:
- Reset (asynchronous, rst_n low) clears every register:
  - prog_we = 0, cfg_we = 0, prog_addr = 0, prog_data = 0, prog_mask = 2'b11, prog_ba = 0, cfg_addr = 0, cfg_data = 0, overflow = 0, busy = 0.
  - FIFO empty, holding register empty.
  - A reset mid-write aborts the write; no replay.
- Accepted byte: ioctl_wr && downloading. ioctl_wr while downloading is low is ignored.
- Config capture: an accepted byte with ioctl_addr < REGSIZE drives cfg_we = 1 on the next cycle, with cfg_addr = ioctl_addr[4:0] and cfg_data = ioctl_data. The byte still goes to SDRAM.
- Bank mapping (byte address A):
  - ba = 3 if A >= BA3_START; else 2 if A >= BA2_START; else 1 if A >= BA1_START; else 0.
  - Word address = (A - start[ba]) >> 1, with start[0] = 0.
- Single-byte entry:
  - Even A: mask 2'b10.
  - Odd A: mask 2'b01.
  - The byte is replicated on both data lanes.
- Packer, PACK=1 (hold register = one byte plus its address; at most one FIFO push per cycle):
  - Hold empty: the accepted byte goes into hold.
  - Hold full, held address even, and new A == held + 1: push a word entry (mask 2'b00) and empty hold.
  - Hold full, any other case: push the held byte as a single-byte entry; the new byte replaces hold.
  - Falling edge of downloading with hold full: push the held byte as a single-byte entry.
- Packer, PACK=0: every accepted byte is pushed next cycle as a single-byte entry. The hold register is unused.
- FIFO entry: {ba, word address, data16, mask}. Push latency is 1 cycle after the triggering event.
- Full FIFO:
  - A push that coincides with a pop is accepted.
  - Otherwise the entry is dropped and overflow is set.
  - overflow clears on reset or on the rising edge of downloading.
- Output FSM:
  - IDLE: when the FIFO is non-empty, load the head into prog_* and go to REQ with prog_we = 1 (head-to-prog_we latency 1 cycle).
  - REQ: prog_we and prog_* stay stable until sdram_ack. On the ack cycle, pop the head, clear prog_we and go to GAP.
  - GAP: one idle cycle, then IDLE. Back-to-back writes are therefore spaced 3 cycles minimum.
  - An ack while prog_we is low is ignored.
- downloading low does not abort anything. The FIFO drains normally and the hold register is flushed as above.
- busy = hold full | FIFO non-empty | prog_we (registered).
- Word address arithmetic wraps modulo 2**(AW-1). No saturation.

Test Plan:
- PACK=1: bytes 0x11 @0x000200 then 0x22 @0x000201, ack 2 cycles after prog_we -> one write: addr 0x100, data 0x2211, mask 00, ba 0.
- Single byte 0xAB @0x100003, then downloading falls -> flushed write: ba 1, addr 0x000001, mask 01, data 0xABAB, busy low after ack.
- REGSIZE=4: bytes 0..5 written -> cfg_we pulses exactly 4 times (cfg_addr 0..3, matching data); 3 SDRAM word writes.
- FIFO_AW=2, sdram_ack held low, 12 odd-address bytes at consecutive odd addresses -> first 4 entries queued, later ones dropped, overflow = 1. Release ack -> exactly 4 writes in order. Rising edge of downloading clears overflow.
- rst_n pulsed low while prog_we = 1 -> all outputs return to reset values immediately; no write issued after release until new ioctl_wr.
- PACK=0, byte at 0x400000 -> ba 3, addr 0, mask 10. Bytes at odd-then-even addresses -> two separate writes, never merged.
